// File: rtl/wisc_pkg.sv
// wisc_pkg: definitions shared by the flag unit and its merge sub-block.
//   - opcode encodings that affect the {N,V,Z} flags
//   - flag bit positions within the 3-bit flag vector
//   - flag_mask(): per-opcode flag write mask; sets_flags(): any flag written
//   - fu_state_t: pending-writer tracking states
package wisc_pkg;

   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_SUB    = 4'h1;
   localparam logic [3:0] OP_XOR    = 4'h2;
   localparam logic [3:0] OP_RED    = 4'h3;
   localparam logic [3:0] OP_SLL    = 4'h4;
   localparam logic [3:0] OP_SRA    = 4'h5;
   localparam logic [3:0] OP_ROR    = 4'h6;
   localparam logic [3:0] OP_PADDSB = 4'h7;

   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } fu_state_t;

   // Arithmetic ops write all flags, logical/shift ops only Z, the rest none.
   function automatic logic [2:0] flag_mask(input logic [3:0] opcode);
      logic [2:0] mask;
      case (opcode)
         OP_ADD, OP_SUB:                 mask = 3'b111;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask = 3'b001;
         default:                        mask = 3'b000;
      endcase
      return mask;
   endfunction

   function automatic logic sets_flags(input logic [3:0] opcode);
      return |flag_mask(opcode);
   endfunction

endpackage

// File: rtl/flag_merge.sv
// flag_merge: combinational merge of freshly computed flags into the held flags.
//   mask_i      : which flag bits the EX instruction writes
//   new_flags_i : {N,V,Z} derived from the current ALU result
//   old_flags_i : currently held architectural flags
//   merged_o    : new bits where mask is set, old bits elsewhere
module flag_merge
   import wisc_pkg::*;
(
   input  logic [2:0] mask_i,
   input  logic [2:0] new_flags_i,
   input  logic [2:0] old_flags_i,
   output logic [2:0] merged_o
);

   // Bitwise select between new and retained flags.
   always_comb begin
      merged_o = (new_flags_i & mask_i) | (old_flags_i & ~mask_i);
   end

endmodule

// File: rtl/flag_unit.sv
// flag_unit: produces the {N,V,Z} flag vector read by the branch logic.
//   clk, rst_n           : clock (rising edge), async active-low reset
//   ex_valid/ex_opcode   : instruction currently in EX
//   alu_result/alu_ovfl  : ALU outputs for that instruction
//   id_issue/id_opcode   : instruction being issued from decode into EX
//   stall, flush         : pipeline freeze / squash of ID and EX
//   br_valid, br_ready   : decode-stage branch handshake
//   F                    : flags for branch evaluation (EX bypass or held)
//   flags_q              : architectural flag register
module flag_unit
   import wisc_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int OP_W   = 4
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid,
   input  logic [OP_W-1:0]   ex_opcode,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_ovfl,
   input  logic              id_issue,
   input  logic [OP_W-1:0]   id_opcode,
   input  logic              stall,
   input  logic              flush,
   input  logic              br_valid,
   output logic              br_ready,
   output logic [2:0]        F,
   output logic [2:0]        flags_q
);

   fu_state_t  state_q;
   fu_state_t  state_d;
   logic [2:0] flags_d;
   logic [2:0] new_flags_s;
   logic [2:0] ex_mask_s;
   logic [2:0] merged_wr_s;
   logic [2:0] merged_byp_s;
   logic       we_s;
   logic       bypass_s;
   logic       ex_sets_s;
   logic       id_sets_s;
   logic       unused_s;

   // Raw flag values and opcode decode for the EX and ID instructions.
   always_comb begin
      new_flags_s[FLAG_N] = alu_result[DATA_W-1];
      new_flags_s[FLAG_V] = alu_ovfl;
      new_flags_s[FLAG_Z] = (alu_result == {DATA_W{1'b0}});
      ex_mask_s           = flag_mask(ex_opcode);
      ex_sets_s           = sets_flags(ex_opcode);
      id_sets_s           = sets_flags(id_opcode);
      we_s                = ex_valid & ~stall & ~flush & ex_sets_s;
      // Stall does not hide the bypass: a frozen EX op still shows its flags.
      bypass_s            = ex_valid & ~flush & ex_sets_s;
      // br_valid carries no decision: br_ready is already 1 whenever nothing is pending.
      unused_s            = br_valid;
   end

   flag_merge u_merge_wr (
      .mask_i      (ex_mask_s),
      .new_flags_i (new_flags_s),
      .old_flags_i (flags_q),
      .merged_o    (merged_wr_s)
   );

   flag_merge u_merge_byp (
      .mask_i      (ex_mask_s),
      .new_flags_i (new_flags_s),
      .old_flags_i (flags_q),
      .merged_o    (merged_byp_s)
   );

   // Next architectural flag value.
   always_comb begin
      if (we_s) begin
         flags_d = merged_wr_s;
      end else begin
         flags_d = flags_q;
      end
   end

   // Architectural flag register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= 3'b000;
      end else begin
         flags_q <= flags_d;
      end
   end

   // Pending-writer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: flush squashes everything; a new flag-setting issue
   // wins over retirement of the old one, since only one can be in flight.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else if (stall) begin
         state_d = state_q;
      end else if (id_issue && id_sets_s) begin
         state_d = PENDING;
      end else if (state_q == PENDING && ex_valid && ex_sets_s) begin
         state_d = IDLE;
      end else begin
         state_d = state_q;
      end
   end

   // Outputs: branch may proceed once the pending writer is visible on F.
   always_comb begin
      br_ready = (state_q != PENDING) | (ex_valid & ex_sets_s);
      if (bypass_s) begin
         F = merged_byp_s;
      end else begin
         F = flags_q;
      end
   end

endmodule
